// File: rtl/vote_pkg.sv
// vote_pkg: shared types and constants for the voter capture block.
package vote_pkg;
    localparam int N_VOTERS = 5;
    localparam int TCNT_W = 16;
    typedef enum logic [1:0] {IDLE, OPEN, DONE} state_t;
endpackage

// File: rtl/debounce.sv
// debounce: 2-flop synchroniser plus consecutive-sample debouncer for one switch.
module debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);
    logic s1;
    logic s2;
    logic [7:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            stable <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == stable) cnt <= '0;
            else if (cnt == 8'(DEB_CYCLES - 1)) begin
                stable <= s2;
                cnt <= '0;
            end else cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: rtl/vote_capture.sv
// vote_capture: debounces voter switches and latches one ballot per session
// when the session is closed or times out.
module vote_capture
    import vote_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_VOTERS-1:0] sw_in,
    input  logic                start,
    input  logic                close,
    output logic [N_VOTERS-1:0] Datain,
    output logic                ballot_valid,
    output logic                open
);
    state_t state;
    state_t next;
    logic [TCNT_W-1:0] tcnt;
    logic [N_VOTERS-1:0] stable;
    logic fire;
    for (genvar g = 0; g < N_VOTERS; g++) begin : g_deb
        debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk(clk),
            .rst(rst),
            .raw(sw_in[g]),
            .stable(stable[g])
        );
    end
    // close and timeout share one transition, so they can only latch once
    always_comb begin
        fire = (state == OPEN) && (close || tcnt == TCNT_W'(TIMEOUT - 1));
        next = state == IDLE ? (start ? OPEN : IDLE) :
               state == OPEN ? (fire ? DONE : OPEN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tcnt <= '0;
            Datain <= '0;
            ballot_valid <= 1'b0;
        end else begin
            state <= next;
            tcnt <= (state == OPEN) ? tcnt + 16'd1 : '0;
            ballot_valid <= fire;
            if (fire) Datain <= stable;
        end
    end
    assign open = (state == OPEN);
endmodule

// File: tb/tb_vote_capture.sv
// tb_vote_capture: directed table-driven bench for vote_capture.
module tb_vote_capture;
    localparam int D = 4;
    typedef struct {
        logic [4:0] sw;
        int hold;
        logic [4:0] exp;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] sw_in = '0;
    logic start = 1'b0, close = 1'b0, start_t = 1'b0, close_t = 1'b0;
    logic [4:0] datain, datain_t;
    logic valid, valid_t, open, open_t;
    int vcnt = 0, vcnt_t = 0, n_tests = 0, n_fail = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    vote_capture #(.DEB_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in), .start(start), .close(close),
        .Datain(datain), .ballot_valid(valid), .open(open)
    );
    vote_capture #(.DEB_CYCLES(D), .TIMEOUT(10)) dut_t (
        .clk(clk), .rst(rst), .sw_in(sw_in), .start(start_t), .close(close_t),
        .Datain(datain_t), .ballot_valid(valid_t), .open(open_t)
    );

    always @(negedge clk) begin
        if (valid) vcnt++;
        if (valid_t) vcnt_t++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_session(input logic [4:0] sw, input int hold,
                               output logic [4:0] d, output int pulses, output logic op);
        int p0;
        sw_in = sw;
        repeat (D + 4) tick();
        p0 = vcnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        op = open;
        repeat (hold) tick();
        close = 1'b1;
        tick();
        close = 1'b0;
        repeat (3) tick();
        pulses = vcnt - p0;
        d = datain;
    endtask

    initial begin
        logic [4:0] d;
        int pulses, p0;
        logic op;
        vec_t v;
        v.sw = 5'b10110; v.hold = 19; v.exp = 5'b10110;
        vecs.push_back(v);
        for (int i = 0; i < 32; i++) begin
            v.sw = 5'(i); v.hold = i % 7; v.exp = 5'(i);
            vecs.push_back(v);
        end

        repeat (3) tick();
        chk("reset_datain", 32'(datain), 0);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_open", 32'(open), 0);
        rst = 1'b0;
        tick();

        foreach (vecs[k]) begin
            run_session(vecs[k].sw, vecs[k].hold, d, pulses, op);
            chk($sformatf("sess%0d_datain", k), 32'(d), 32'(vecs[k].exp));
            chk($sformatf("sess%0d_pulses", k), pulses, 1);
            chk($sformatf("sess%0d_open", k), 32'(op), 1);
            chk($sformatf("sess%0d_closed", k), 32'(open), 0);
        end

        // 3-cycle glitch on bit 0 during OPEN must not be captured
        sw_in = '0;
        repeat (D + 4) tick();
        p0 = vcnt;
        start = 1'b1; tick(); start = 1'b0;
        sw_in = 5'b00001; repeat (3) tick(); sw_in = '0;
        repeat (D + 4) tick();
        close = 1'b1; tick(); close = 1'b0;
        repeat (3) tick();
        chk("glitch_datain", 32'(datain), 0);
        chk("glitch_pulses", vcnt - p0, 1);

        // votes changed during OPEN are captured
        start = 1'b1; tick(); start = 1'b0;
        sw_in = 5'b10101; repeat (D + 4) tick();
        close = 1'b1; tick(); close = 1'b0;
        repeat (3) tick();
        chk("change_in_open", 32'(datain), 32'(5'b10101));

        // latency boundary: new value visible after exactly 2+D edges
        for (int n = 5; n <= 6; n++) begin
            sw_in = '0;
            repeat (D + 4) tick();
            start = 1'b1; tick(); start = 1'b0;
            repeat (2) tick();
            sw_in = 5'b01010;
            repeat (n) tick();
            close = 1'b1; tick(); close = 1'b0;
            repeat (3) tick();
            chk($sformatf("latency_n%0d", n), 32'(datain), n == 5 ? 0 : 32'(5'b01010));
        end

        // simultaneous start+close in IDLE opens; start in OPEN/DONE ignored
        sw_in = 5'b00111;
        repeat (D + 4) tick();
        p0 = vcnt;
        start = 1'b1; close = 1'b1; tick(); start = 1'b0; close = 1'b0;
        chk("start_close_open", 32'(open), 1);
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        chk("start_close_nopulse", vcnt - p0, 0);
        chk("start_in_open", 32'(open), 1);
        close = 1'b1; tick(); close = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("start_in_done", 32'(open), 0);
        repeat (3) tick();
        chk("start_close_pulses", vcnt - p0, 1);
        chk("start_close_datain", 32'(datain), 32'(5'b00111));

        // close in IDLE ignored
        p0 = vcnt;
        close = 1'b1; tick(); close = 1'b0;
        repeat (3) tick();
        chk("close_idle_pulses", vcnt - p0, 0);
        chk("close_idle_open", 32'(open), 0);
        chk("close_idle_datain", 32'(datain), 32'(5'b00111));

        // timeout after 10 OPEN cycles
        sw_in = 5'b11100;
        repeat (D + 4) tick();
        p0 = vcnt_t;
        start_t = 1'b1; tick(); start_t = 1'b0;
        chk("to_open", 32'(open_t), 1);
        repeat (9) tick();
        chk("to_early", 32'(valid_t), 0);
        tick();
        chk("to_valid", 32'(valid_t), 1);
        chk("to_datain", 32'(datain_t), 32'(5'b11100));
        tick();
        chk("to_valid_drop", 32'(valid_t), 0);
        chk("to_closed", 32'(open_t), 0);
        chk("to_pulses", vcnt_t - p0, 1);

        // close on the very cycle the timeout fires
        p0 = vcnt_t;
        start_t = 1'b1; tick(); start_t = 1'b0;
        repeat (9) tick();
        close_t = 1'b1; tick(); close_t = 1'b0;
        chk("to_close_valid", 32'(valid_t), 1);
        repeat (3) tick();
        chk("to_close_pulses", vcnt_t - p0, 1);
        chk("to_close_closed", 32'(open_t), 0);
        start_t = 1'b1; tick(); start_t = 1'b0;
        chk("to_close_reopen", 32'(open_t), 1);
        repeat (12) tick();

        // reset mid-session aborts without a pulse
        sw_in = 5'b11111;
        repeat (D + 4) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        p0 = vcnt;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_open_datain", 32'(datain), 0);
        chk("rst_open_open", 32'(open), 0);
        chk("rst_open_valid", 32'(valid), 0);
        repeat (5) tick();
        chk("rst_open_nopulse", vcnt - p0, 0);

        // switch already high at reset release reaches stable after 2+D edges
        for (int n = 4; n <= 5; n++) begin
            rst = 1'b1; tick(); rst = 1'b0;
            start = 1'b1; tick(); start = 1'b0;
            repeat (n) tick();
            close = 1'b1; tick(); close = 1'b0;
            repeat (3) tick();
            chk($sformatf("post_rst_n%0d", n), 32'(datain), n == 4 ? 0 : 32'(5'b11111));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vote_capture.md
VOTE_CAPTURE -- requirements
Module: vote_capture

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 4, meaning consecutive stable samples needed to accept a switch change (legal 2..255).
REQ-002 The block SHALL have parameter TIMEOUT, default 1000, meaning maximum OPEN-state cycles before auto-close (legal 1..65535).
REQ-003 The block SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port sw_in  input  5  raw asynchronous voter switches, bit i = voter i, 1 = yes.
REQ-006 The block SHALL have port start  input  1  single-cycle request to open a voting session.
REQ-007 The block SHALL have port close  input  1  single-cycle request to end the session.
REQ-008 The block SHALL have port Datain  output  5  latched ballot, directly feeding the downstream 5-voter majority stage.
REQ-009 The block SHALL have port ballot_valid  output  1  one-cycle pulse when Datain is newly latched.
REQ-010 The block SHALL have port open  output  1  high while a session is in the OPEN state.

Function
REQ-011 Each sw_in bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-012 Debounce, per bit: if the synchronised value differs from the stable value for DEB_CYCLES consecutive cycles, the stable value SHALL take the new value; any matching cycle SHALL clear that bit's counter.
REQ-013 A glitch shorter than DEB_CYCLES cycles SHALL NOT change the stable value; worst-case latency from sw_in to the stable value SHALL be 2+DEB_CYCLES cycles.
REQ-014 The FSM SHALL have states IDLE, OPEN and DONE; the reset state SHALL be IDLE.
REQ-015 IDLE->OPEN SHALL occur on start=1, and the timeout counter SHALL clear to 0.
REQ-016 In OPEN, the timeout counter SHALL increment by 1 per cycle and open SHALL be 1.
REQ-017 OPEN->DONE SHALL occur on close=1 or when the counter equals TIMEOUT-1, whichever comes first.
REQ-018 On the OPEN->DONE transition edge, Datain SHALL load the current debounced vector, and ballot_valid SHALL be 1 in the following cycle only.
REQ-019 DONE->IDLE SHALL occur unconditionally after one cycle; Datain SHALL hold its value until the next latch or reset.
REQ-020 Simultaneous start and close in IDLE SHALL open the session and ignore close.
REQ-021 Simultaneous close and timeout SHALL latch once, producing a single ballot_valid pulse.
REQ-022 start while in OPEN or DONE SHALL be ignored.
REQ-023 close outside OPEN SHALL be ignored.
REQ-024 Debouncing SHALL run continuously in every state, so that votes changed during OPEN are captured at close.
REQ-025 The timeout counter SHALL be 16 bits wide and SHALL NOT wrap, because the FSM leaves OPEN first.

Reset
REQ-026 While rst=1 at a rising clk edge, the following SHALL apply: state=IDLE, Datain=5'b00000, ballot_valid=0, open=0, timeout counter=0, all debounce counters=0, stable and synchroniser flops=0.
REQ-027 rst asserted mid-session SHALL abort the session without a ballot_valid pulse.
REQ-028 After rst is released, a switch already high SHALL appear in the stable vector after 2+DEB_CYCLES cycles.

Structure
REQ-029 Shared package vote_pkg SHALL hold the FSM state enum (IDLE, OPEN, DONE), the constant N_VOTERS=5, and the timeout counter width (16).
REQ-030 A sub-module debounce SHALL be instantiated once per voter (5 copies) and SHALL contain the synchroniser, counter and stable flop for one bit.
REQ-031 vote_capture SHALL contain the FSM, the timeout counter and the Datain/ballot_valid registers.

Verification
REQ-032 With DEB_CYCLES=4, drive sw_in=5'b10110 steady, pulse start, pulse close 20 cycles later -> Datain=5'b10110 and ballot_valid high exactly one cycle.
REQ-033 Apply a 3-cycle high glitch on sw_in[0] during OPEN, then close -> Datain[0]=0.
REQ-034 With TIMEOUT=10, pulse start, never close, sw_in=5'b11100 -> ballot_valid pulses 10 cycles after OPEN entry and Datain=5'b11100.
REQ-035 Pulse close at the same cycle timeout fires -> exactly one ballot_valid pulse, then state returns to IDLE.
REQ-036 Assert rst during OPEN with sw_in=5'b11111 -> no ballot_valid pulse, Datain=0 and open=0 on the next cycle.
REQ-037 Sweep sw_in through all 32 values, one session each -> Datain equals the stable input in every session, giving full coverage of the downstream majority stage.
